// File: rtl/cam_data_fetch_if.sv
// ---------------------------------------------------------------------------
// cam_data_fetch_if
// Bundles the request, subarray-bank and readback signals of the CAM read
// fetch engine into one interface.
//   slave  : the fetch engine itself (cam_data_fetch)
//   master : whoever drives requests, models the subarrays and consumes words
// Signals:
//   start, base_row, num_vectors     fetch request
//   read_done_all, rd_data           subarray read strobes and shared read bus
//   chip_enable, rd_row              one-hot subarray select and row address
//   out_data/sub/row/err/valid/ready streamed word with valid/ready handshake
//   busy, done, done_all             progress status and pulses
//   timeout_err                      sticky missing-word flag
// ---------------------------------------------------------------------------
interface cam_data_fetch_if #(
  parameter int NUM_SUB = 16,
  parameter int DATA_W  = 16,
  parameter int ROW_W   = 5
);
  logic               start;
  logic [ROW_W-1:0]   base_row;
  logic [3:0]         num_vectors;
  logic [NUM_SUB-1:0] read_done_all;
  logic [DATA_W-1:0]  rd_data;
  logic [NUM_SUB-1:0] chip_enable;
  logic [ROW_W-1:0]   rd_row;
  logic [DATA_W-1:0]  out_data;
  logic [3:0]         out_sub;
  logic [ROW_W-1:0]   out_row;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               done_all;
  logic               timeout_err;

  modport slave (
    input  start, base_row, num_vectors, read_done_all, rd_data, out_ready,
    output chip_enable, rd_row, out_data, out_sub, out_row, out_err,
           out_valid, busy, done, done_all, timeout_err
  );

  modport master (
    output start, base_row, num_vectors, read_done_all, rd_data, out_ready,
    input  chip_enable, rd_row, out_data, out_sub, out_row, out_err,
           out_valid, busy, done, done_all, timeout_err
  );
endinterface

// File: rtl/cam_data_fetch.sv
// ---------------------------------------------------------------------------
// cam_data_fetch
// Read-side fetch engine for the CAM subarray bank. Starting at a row, it
// selects each subarray in turn with a one-hot chip_enable, waits for that
// subarray's read_done, captures the shared read bus and streams the word out
// over valid/ready. A subarray that never answers yields a zero filler word
// flagged with out_err and sets the sticky timeout_err.
// Ports:
//   CLK     clock, rising edge
//   rst     synchronous active-low reset
//   io_bus  cam_data_fetch_if.slave (request, subarray bank, readback side)
// ---------------------------------------------------------------------------
module cam_data_fetch #(
  parameter int NUM_SUB = 16,
  parameter int DATA_W  = 16,
  parameter int ROW_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            CLK,
  input  logic            rst,
  cam_data_fetch_if.slave io_bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    OUT
  } state_t;

  state_t             r_state, w_state;
  logic [3:0]         r_numVec, w_numVec;
  logic [3:0]         r_rowCnt, w_rowCnt;
  logic [3:0]         r_subIdx, w_subIdx;
  logic [TMO_W-1:0]   r_tmoCnt, w_tmoCnt;
  logic [NUM_SUB-1:0] r_chipEn, w_chipEn;
  logic [ROW_W-1:0]   r_rdRow, w_rdRow;
  logic [DATA_W-1:0]  r_outData, w_outData;
  logic [3:0]         r_outSub, w_outSub;
  logic [ROW_W-1:0]   r_outRow, w_outRow;
  logic               r_outErr, w_outErr;
  logic               r_outValid, w_outValid;
  logic               r_done, w_done;
  logic               r_doneAll, w_doneAll;
  logic               r_tmoErr, w_tmoErr;
  logic               w_ack;

  // State and every output live in this single register bank so all outputs
  // come straight from flops; reset wipes everything, including any word
  // still waiting for the consumer.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_numVec   <= '0;
      r_rowCnt   <= '0;
      r_subIdx   <= '0;
      r_tmoCnt   <= '0;
      r_chipEn   <= '0;
      r_rdRow    <= '0;
      r_outData  <= '0;
      r_outSub   <= '0;
      r_outRow   <= '0;
      r_outErr   <= 1'b0;
      r_outValid <= 1'b0;
      r_done     <= 1'b0;
      r_doneAll  <= 1'b0;
      r_tmoErr   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_numVec   <= w_numVec;
      r_rowCnt   <= w_rowCnt;
      r_subIdx   <= w_subIdx;
      r_tmoCnt   <= w_tmoCnt;
      r_chipEn   <= w_chipEn;
      r_rdRow    <= w_rdRow;
      r_outData  <= w_outData;
      r_outSub   <= w_outSub;
      r_outRow   <= w_outRow;
      r_outErr   <= w_outErr;
      r_outValid <= w_outValid;
      r_done     <= w_done;
      r_doneAll  <= w_doneAll;
      r_tmoErr   <= w_tmoErr;
    end
  end

  // Next-state logic. Registers hold by default; done/done_all default low
  // so they only ever last one cycle. The timeout counter defaults to zero,
  // so it only grows while a subarray is being waited on and starts fresh on
  // every entry to WAIT_ACK. Only strobes from the currently selected
  // subarray count as an acknowledge. A timeout takes the same path as an
  // acknowledge but substitutes a zero word marked as an error.
  always_comb begin
    w_state    = r_state;
    w_numVec   = r_numVec;
    w_rowCnt   = r_rowCnt;
    w_subIdx   = r_subIdx;
    w_tmoCnt   = '0;
    w_chipEn   = r_chipEn;
    w_rdRow    = r_rdRow;
    w_outData  = r_outData;
    w_outSub   = r_outSub;
    w_outRow   = r_outRow;
    w_outErr   = r_outErr;
    w_outValid = r_outValid;
    w_done     = 1'b0;
    w_doneAll  = 1'b0;
    w_tmoErr   = r_tmoErr;
    w_ack      = |(io_bus.read_done_all & r_chipEn);

    unique case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_tmoErr = 1'b0;
          if (io_bus.num_vectors != 4'd0) begin
            w_numVec = io_bus.num_vectors;
            w_rdRow  = io_bus.base_row;
            w_rowCnt = '0;
            w_subIdx = '0;
            w_chipEn = NUM_SUB'(1);
            w_state  = WAIT_ACK;
          end else begin
            w_doneAll = 1'b1;
          end
        end
      end

      WAIT_ACK: begin
        if (w_ack || (r_tmoCnt == TMO_W'(TIMEOUT - 1))) begin
          w_outData  = w_ack ? io_bus.rd_data : '0;
          w_outErr   = !w_ack;
          w_tmoErr   = r_tmoErr | !w_ack;
          w_outSub   = r_subIdx;
          w_outRow   = r_rdRow;
          w_outValid = 1'b1;
          w_chipEn   = '0;
          w_state    = OUT;
        end else begin
          w_tmoCnt = r_tmoCnt + TMO_W'(1);
        end
      end

      OUT: begin
        if (r_outValid && io_bus.out_ready) begin
          w_outValid = 1'b0;
          if (r_subIdx != 4'(NUM_SUB - 1)) begin
            w_subIdx = r_subIdx + 4'd1;
            w_chipEn = NUM_SUB'(1) << (r_subIdx + 4'd1);
            w_state  = WAIT_ACK;
          end else if (r_rowCnt != (r_numVec - 4'd1)) begin
            w_done   = 1'b1;
            w_rowCnt = r_rowCnt + 4'd1;
            w_rdRow  = r_rdRow + ROW_W'(1);
            w_subIdx = '0;
            w_chipEn = NUM_SUB'(1);
            w_state  = WAIT_ACK;
          end else begin
            w_done    = 1'b1;
            w_doneAll = 1'b1;
            w_state   = IDLE;
          end
        end
      end

      default: w_state = IDLE;
    endcase
  end

  assign io_bus.chip_enable = r_chipEn;
  assign io_bus.rd_row      = r_rdRow;
  assign io_bus.out_data    = r_outData;
  assign io_bus.out_sub     = r_outSub;
  assign io_bus.out_row     = r_outRow;
  assign io_bus.out_err     = r_outErr;
  assign io_bus.out_valid   = r_outValid;
  assign io_bus.busy        = (r_state != IDLE);
  assign io_bus.done        = r_done;
  assign io_bus.done_all    = r_doneAll;
  assign io_bus.timeout_err = r_tmoErr;

endmodule
